// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//   Drives a 2-input combinational gate through all four input vectors,
//   samples its output after a settle delay and compares each sample against
//   a captured 4-entry truth table. Reports a saturating error count, the
//   first failing vector and a registered pass/done verdict.
//   Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       tt_exp,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0]       CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t     state;
  logic [1:0] vec;
  logic [7:0] cnt;
  logic [3:0] tt_q;
  logic       mismatch;

  // The vector register is the single source of truth for the GUT inputs.
  assign a = vec[1];
  assign b = vec[0];

  // Current GUT output disagrees with the captured expectation for this vector.
  assign mismatch = (y != tt_q[vec]);

  // Sweep sequencer: launch, settle, sample, and verdict bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= 2'd0;
      cnt        <= 8'd0;
      tt_q       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tt_q       <= tt_exp;
            vec        <= 2'd0;
            cnt        <= CNT_INIT;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
              err_cnt <= err_cnt + ERR_ONE;
            end
            // Only the first failing vector of a sweep is kept.
            if (!fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (vec == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // fail_valid covers earlier vectors; mismatch covers this one.
            pass  <= !fail_valid && !mismatch;
          end else begin
            vec   <= vec + 2'd1;
            cnt   <= CNT_INIT;
            state <= SETTLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_checker
//   Directed bench for gate_sweep_checker. Two instances (ERR_W=3 and ERR_W=2)
//   run in lockstep against a bench-modelled GUT. A timeline model derives the
//   expected outputs from the number of edges since the accepted start.
//   Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_checker;

  localparam int SETTLE = 2;
  localparam int SLOT   = SETTLE + 1;   // cycles per vector
  localparam int SWEEP  = 4 * SLOT;     // edges from start to done

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] tt_exp = 4'b1000;
  int         mode = 0;                 // 0: AND, 1: stuck-at-0, 2: NAND

  logic       y3, a3, b3, busy3, done3, pass3, fv3;
  logic [2:0] ec3;
  logic [1:0] fvec3;
  logic       y2, a2, b2, busy2, done2, pass2, fv2;
  logic [1:0] ec2;
  logic [1:0] fvec2;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic gut(input int m, input logic [1:0] v);
    case (m)
      0:       return v[1] & v[0];
      1:       return 1'b0;
      default: return ~(v[1] & v[0]);
    endcase
  endfunction

  assign y3 = gut(mode, {a3, b3});
  assign y2 = gut(mode, {a2, b2});

  gate_sweep_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_exp(tt_exp), .y(y3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(ec3), .fail_valid(fv3), .fail_vec(fvec3)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_exp(tt_exp), .y(y2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(ec2), .fail_valid(fv2), .fail_vec(fvec2)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  bit         m_active = 1'b0;
  int         m_phase  = 0;
  logic [3:0] m_tt     = 4'd0;
  int         m_mode   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_phase  = 0;
    end else if ((!m_active || m_phase >= SWEEP) && start) begin
      m_active = 1'b1;
      m_phase  = 0;
      m_tt     = tt_exp;
      m_mode   = mode;
    end else if (m_active && m_phase < SWEEP) begin
      m_phase++;
    end
  end

  task automatic compare_inst(input string tag, input int w, input logic [1:0] ab,
                              input logic bsy, input logic dn, input logic ps,
                              input int ec, input logic fv, input logic [1:0] fvec);
    int n, errs, first, vec, cap;
    logic [1:0] v;
    errs = 0; first = 0; vec = 0; n = 0;
    cap = (1 << w) - 1;
    if (m_active) begin
      n   = (m_phase / SLOT > 4) ? 4 : m_phase / SLOT;
      vec = (m_phase >= SWEEP) ? 3 : m_phase / SLOT;
      for (int i = 0; i < n; i++) begin
        v = 2'(i);
        if (gut(m_mode, v) != m_tt[i]) begin
          if (errs == 0) first = i;
          errs++;
        end
      end
    end
    check({tag, ".ab"},   int'(ab),  vec);
    check({tag, ".busy"}, int'(bsy), (m_active && m_phase < SWEEP) ? 1 : 0);
    check({tag, ".done"}, int'(dn),  (m_active && m_phase >= SWEEP) ? 1 : 0);
    check({tag, ".pass"}, int'(ps),  (m_active && m_phase >= SWEEP && errs == 0) ? 1 : 0);
    check({tag, ".err_cnt"}, ec, (errs > cap) ? cap : errs);
    check({tag, ".fail_valid"}, int'(fv), (errs > 0) ? 1 : 0);
    check({tag, ".fail_vec"}, int'(fvec), first);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      compare_inst("w3", 3, {a3, b3}, busy3, done3, pass3, int'(ec3), fv3, fvec3);
      compare_inst("w2", 2, {a2, b2}, busy2, done2, pass2, int'(ec2), fv2, fvec2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check("reset.done", int'(done3), 0);
    check("reset.err_cnt", int'(ec3), 0);
    @(negedge clk) rst_n = 1'b1;

    // Ideal AND, tt=1000: vectors change every SLOT edges, pass at +12.
    mode = 0; tt_exp = 4'b1000;
    launch();                           // edge k is now behind us
    check("and.ab_k", int'({a3, b3}), 0);
    wait_edges(3);
    check("and.ab_k3", int'({a3, b3}), 1);
    wait_edges(3);
    check("and.ab_k6", int'({a3, b3}), 2);
    wait_edges(5);
    check("and.done_k11", int'(done3), 0);
    wait_edges(1);
    check("and.done_k12", int'(done3), 1);
    check("and.pass", int'(pass3), 1);
    wait_edges(2);

    // Stuck-at-0 output: only vector 11 fails.
    mode = 1;
    launch();
    wait_edges(SWEEP + 1);
    check("zero.err_cnt", int'(ec3), 1);
    check("zero.fail_vec", int'(fvec3), 3);
    check("zero.pass", int'(pass3), 0);

    // Restart from DONE after a failing sweep with a good gate.
    mode = 0;
    launch();
    check("rerun.err_clear", int'(ec3), 0);
    check("rerun.fv_clear", int'(fv3), 0);
    wait_edges(SWEEP + 1);
    check("rerun.pass", int'(pass3), 1);

    // NAND: every vector fails; narrow counter saturates.
    mode = 2;
    launch();
    wait_edges(SWEEP + 1);
    check("nand.err_cnt_w3", int'(ec3), 4);
    check("nand.err_cnt_w2", int'(ec2), 3);
    check("nand.fail_vec", int'(fvec3), 0);
    check("nand.pass", int'(pass3), 0);

    // Restart attempt and truth-table change while busy are ignored.
    mode = 0; tt_exp = 4'b1000;
    launch();
    wait_edges(3);
    @(negedge clk) tt_exp = 4'b0110;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_edges(SWEEP);
    check("busy_restart.pass", int'(pass3), 1);
    tt_exp = 4'b1000;

    // Held-high start relaunches at every completion.
    @(negedge clk) start = 1'b1;
    repeat (2 * (SWEEP + 1) + 3) @(negedge clk);
    start = 1'b0;
    wait_edges(SWEEP + 2);

    // Asynchronous reset while vector 2 is settling.
    launch();
    wait_edges(2 * SLOT + 1);
    check("mid.ab_before_reset", int'({a3, b3}), 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid.ab_reset", int'({a3, b3}), 0);
    check("mid.busy_reset", int'(busy3), 0);
    check("mid.err_reset", int'(ec3), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edges(4);
    check("mid.done_idle", int'(done3), 0);

    // Fresh sweep after reset recovery.
    launch();
    wait_edges(SWEEP + 1);
    check("post_reset.pass", int'(pass3), 1);

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking exerciser for a 2-input combinational gate under test (GUT), e.g. and_gate.
- Sits directly upstream and downstream of the GUT: drives its a/b inputs through all four combinations and samples its y output.
- Compares each sample against a caller-supplied 4-entry truth table.
- Reports error count, first failing vector and pass/done status, so benches and on-board demos get a hardware verdict without reading a waveform.

Parameters:
SETTLE_CYCLES, 2, cycles a/b are held before y is sampled; legal range 1..255
ERR_W, 3, width of the saturating error counter; legal range 2..8

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse/level; begins a sweep when accepted
tt_exp  input  4  expected truth table; tt_exp[{a,b}] is the expected y
y  input  1  GUT output
a  output  1  GUT input a (MSB of vector index)
b  output  1  GUT input b (LSB of vector index)
busy  output  1  sweep in progress
done  output  1  sweep finished; held until next accepted start or reset
pass  output  1  done and zero errors
err_cnt  output  ERR_W  number of mismatching vectors in last sweep, saturating
fail_valid  output  1  at least one mismatch recorded in current/last sweep
fail_vec  output  2  {a,b} of first mismatching vector

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0. Internal vec=0, cnt=0.
- Reset asserted mid-sweep aborts immediately to these values. No partial result survives.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1 at an edge:
  - tt_exp captured into tt_q; later tt_exp changes are ignored until the next start.
  - vec=0, {a,b}=00, cnt=SETTLE_CYCLES-1.
  - err_cnt=0, fail_valid=0, fail_vec=0, done=0, pass=0, busy=1.
  - Next state SETTLE.
- IDLE/DONE with start=0: hold all outputs.
- SETTLE: if cnt==0, go to SAMPLE; else cnt decrements. SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): at the edge, compare y with tt_q[vec].
  - On mismatch: err_cnt increments, saturating at 2^ERR_W-1.
  - On mismatch with fail_valid=0: fail_vec=vec and fail_valid=1. Later mismatches do not overwrite fail_vec.
  - If vec==3: next state DONE, busy=0, done=1, pass = (no mismatch in the whole sweep, including this sample).
  - Else: vec increments, {a,b} updates to the new vec, cnt=SETTLE_CYCLES-1, next state SETTLE.
- a and b are registered outputs equal to vec at all times. They change only on the start edge or on a SAMPLE edge.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - If start is accepted at edge k, done rises after edge k+4*(SETTLE_CYCLES+1). With default 2, that is edge k+12.
  - y is sampled at edges k+3, k+6, k+9 and k+12.
- start while busy is ignored. A held-high start in DONE re-launches a sweep every completion.
- pass is the combinational-free registered flag. pass=1 implies done=1.
- y is assumed stable by the SAMPLE edge. The GUT is combinational, and SETTLE_CYCLES>=1 guarantees at least one full cycle of settling.

Test Plan:
- Ideal AND GUT, tt_exp=4'b1000, start pulse at edge k, SETTLE_CYCLES=2 -> a,b walk 00,01,10,11 changing at k, k+3, k+6, k+9; done=1 and pass=1 after k+12; err_cnt=0, fail_valid=0.
- y tied to 0, tt_exp=4'b1000 -> done after k+12; err_cnt=1, fail_valid=1, fail_vec=2'b11, pass=0.
- NAND GUT vs tt_exp=4'b1000, ERR_W=2 -> 4 mismatches, err_cnt saturates at 3; fail_vec=2'b00; pass=0.
- Reset asserted when vec=2 (mid-SETTLE), released 2 cycles later -> all outputs 0 immediately on assertion; IDLE after release; done stays 0 until a new start.
- start re-pulsed at k+5 while busy, tt_exp changed to 4'b0110 at k+4 -> no restart; results still judged against 4'b1000.
- Second start in DONE after a failing sweep, with an ideal AND GUT -> err_cnt and fail_valid clear on the start edge; ends with pass=1.
